// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_unit_pkg;

  localparam int unsigned INST_W = 9;
  localparam logic [INST_W-1:0] HALT_OP = 9'h1FF;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2,
    ST_HALT = 2'd3
  } state_t;

endpackage

// File: rtl/fetch_unit.sv
// Single-outstanding-request instruction fetch FSM with a held instruction slot.
// Optional build macro FETCH_PERF_CNT_EN adds the fetch_count output.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [31:0]       start_addr,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [31:0]       pc,
  output logic [31:0]       next_pc,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              halted
`ifdef FETCH_PERF_CNT_EN
  ,output logic [31:0]      fetch_count
`endif
);

  state_t            state_q;
  logic [31:0]       pc_q;
  logic [31:0]       pc_d;
  logic [INST_W-1:0] inst_q;
  logic              req_q;
  logic              valid_q;
  logic              halted_q;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]       count_q;
`endif

  // Redirect only matters on the accept edge, where pc_d is consumed.
  assign next_pc = pc_q + PC_STEP;
  assign pc_d    = redirect_valid ? redirect_pc : next_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      inst_q   <= '0;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
`ifdef FETCH_PERF_CNT_EN
      count_q  <= '0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE, ST_HALT: begin
          if (start) begin
            pc_q     <= start_addr;
            req_q    <= 1'b1;
            halted_q <= 1'b0;
            state_q  <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (imem_ack) begin
            inst_q  <= imem_rdata;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
            state_q <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (inst_ready) begin
            valid_q <= 1'b0;
`ifdef FETCH_PERF_CNT_EN
            count_q <= count_q + 32'd1;
`endif
            if (inst_q == HALT_OP) begin
              halted_q <= 1'b1;
              state_q  <= ST_HALT;
            end else begin
              pc_q    <= pc_d;
              req_q   <= 1'b1;
              state_q <= ST_REQ;
            end
          end
        end
      endcase
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = pc_q;
  assign inst_valid = valid_q;
  assign inst       = inst_q;
  assign pc         = pc_q;
  assign halted     = halted_q;
`ifdef FETCH_PERF_CNT_EN
  assign fetch_count = count_q;
`endif

endmodule
